// File: rtl/req_ack_hub.sv
// req_ack_hub: N-channel four-phase REQ/ACK hub.
//   Arbitrates round-robin between requesters whose channel address matches
//   MY_ADDR_IN, forwards the winner to one downstream responder and returns
//   the responder's acknowledge to the winning channel only. A transfer that
//   sees no ACK_IN within TIMEOUT cycles is aborted (0 disables the timeout).
// Ports:
//   CLK_IN, RST_N_IN       clock, asynchronous active-low reset
//   MY_ADDR_IN             local address used for eligibility
//   REQ_IN, CH_ADDR_IN     per-channel request and target address
//   ACK_OUT                per-channel acknowledge (one-hot or zero)
//   REQ_OUT, GRANT_OUT     downstream request and owning channel index
//   ACK_IN                 downstream acknowledge
//   BUSY_OUT               high whenever not idle
//   TIMEOUT_OUT, ERR_OUT   abort pulse and sticky error flag
//   ERR_CLR_IN             clears ERR_OUT (an abort in the same cycle wins)
//   XFER_CNT_OUT           completed-transfer counter, wraps silently
module req_ack_hub #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8,
    parameter int GID_W   = $clog2(NUM_CH)
) (
    input  logic                     CLK_IN,
    input  logic                     RST_N_IN,
    input  logic [ADDR_W-1:0]        MY_ADDR_IN,
    input  logic [NUM_CH-1:0]        REQ_IN,
    input  logic [NUM_CH*ADDR_W-1:0] CH_ADDR_IN,
    output logic [NUM_CH-1:0]        ACK_OUT,
    output logic                     REQ_OUT,
    output logic [GID_W-1:0]         GRANT_OUT,
    input  logic                     ACK_IN,
    output logic                     BUSY_OUT,
    output logic                     TIMEOUT_OUT,
    output logic                     ERR_OUT,
    input  logic                     ERR_CLR_IN,
    output logic [CNT_W-1:0]         XFER_CNT_OUT
);

    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_REL
    } state_t;

    state_t              state_q, state_d;
    logic [GID_W-1:0]    ptr_q, ptr_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                abort_q, abort_d;

    logic [NUM_CH-1:0]   ack_d;
    logic                req_d;
    logic [GID_W-1:0]    grant_d;
    logic                busy_d;
    logic                timeout_d;
    logic                err_d;
    logic [CNT_W-1:0]    cnt_d;

    logic [NUM_CH-1:0]   elig;
    logic                any_elig;
    logic [GID_W-1:0]    pick;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            elig[i] = REQ_IN[i] && (CH_ADDR_IN[i*ADDR_W +: ADDR_W] == MY_ADDR_IN);
        end
    end

    // Search upward from ptr+1; the last offset (NUM_CH) revisits ptr itself,
    // so the previous winner is only chosen when nobody else is eligible.
    always_comb begin
        any_elig = 1'b0;
        pick     = '0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            if (!any_elig && elig[(32'(ptr_q) + off) % 32'(NUM_CH)]) begin
                any_elig = 1'b1;
                pick     = GID_W'((32'(ptr_q) + off) % 32'(NUM_CH));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        abort_d   = abort_q;
        ack_d     = ACK_OUT;
        req_d     = REQ_OUT;
        grant_d   = GRANT_OUT;
        busy_d    = BUSY_OUT;
        timeout_d = 1'b0;
        cnt_d     = XFER_CNT_OUT;
        err_d     = ERR_CLR_IN ? 1'b0 : ERR_OUT;

        case (state_q)
            S_IDLE: begin
                if (any_elig) begin
                    grant_d = pick;
                    ptr_d   = pick;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    timer_d = '0;
                    abort_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // ACK_IN has priority over an expiring timer.
                if (ACK_IN) begin
                    ack_d   = NUM_CH'(1) << GRANT_OUT;
                    state_d = S_HOLD;
                end else if ((TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1))) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    err_d     = 1'b1;
                    abort_d   = 1'b1;
                    state_d   = S_REL;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_HOLD: begin
                if (!REQ_IN[GRANT_OUT]) begin
                    req_d   = 1'b0;
                    state_d = S_REL;
                end
            end
            S_REL: begin
                // Waiting for ACK_IN low here also absorbs a late acknowledge
                // after an abort, so IDLE never starts with one outstanding.
                if (!ACK_IN) begin
                    ack_d   = '0;
                    busy_d  = 1'b0;
                    abort_d = 1'b0;
                    if (!abort_q) begin
                        cnt_d = XFER_CNT_OUT + CNT_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            state_q      <= S_IDLE;
            ptr_q        <= GID_W'(NUM_CH - 1);
            timer_q      <= '0;
            abort_q      <= 1'b0;
            ACK_OUT      <= '0;
            REQ_OUT      <= 1'b0;
            GRANT_OUT    <= '0;
            BUSY_OUT     <= 1'b0;
            TIMEOUT_OUT  <= 1'b0;
            ERR_OUT      <= 1'b0;
            XFER_CNT_OUT <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            timer_q      <= timer_d;
            abort_q      <= abort_d;
            ACK_OUT      <= ack_d;
            REQ_OUT      <= req_d;
            GRANT_OUT    <= grant_d;
            BUSY_OUT     <= busy_d;
            TIMEOUT_OUT  <= timeout_d;
            ERR_OUT      <= err_d;
            XFER_CNT_OUT <= cnt_d;
        end
    end

endmodule

// File: tb/tb_req_ack_hub.sv
// Directed bench for req_ack_hub (NUM_CH=4, ADDR_W=2, TIMEOUT=15, CNT_W=2).
module tb_req_ack_hub;

    logic       clk;
    logic       rst_n;
    logic [1:0] my_addr;
    logic [3:0] req;
    logic [7:0] ch_addr;
    logic [3:0] ack_out;
    logic       req_out;
    logic [1:0] grant;
    logic       ack_in;
    logic       busy;
    logic       timeout;
    logic       err;
    logic       err_clr;
    logic [1:0] cnt;

    int vectors;
    int miscompares;

    req_ack_hub #(
        .NUM_CH (4),
        .ADDR_W (2),
        .TIMEOUT(15),
        .CNT_W  (2)
    ) dut (
        .CLK_IN      (clk),
        .RST_N_IN    (rst_n),
        .MY_ADDR_IN  (my_addr),
        .REQ_IN      (req),
        .CH_ADDR_IN  (ch_addr),
        .ACK_OUT     (ack_out),
        .REQ_OUT     (req_out),
        .GRANT_OUT   (grant),
        .ACK_IN      (ack_in),
        .BUSY_OUT    (busy),
        .TIMEOUT_OUT (timeout),
        .ERR_OUT     (err),
        .ERR_CLR_IN  (err_clr),
        .XFER_CNT_OUT(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},     32'(ack_out), 32'd0);
        chk({tag, "_req_out"}, 32'(req_out), 32'd0);
        chk({tag, "_grant"},   32'(grant),   32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_err"},     32'(err),     32'd0);
        chk({tag, "_cnt"},     32'(cnt),     32'd0);
    endtask

    // One minimal handshake: starts in IDLE with req already set up.
    task automatic do_xfer(input int g, input int cnt_exp, input bit restore);
        chk("xfer_idle_req_out", 32'(req_out), 32'd0);
        tick;
        chk("xfer_grant",    32'(grant),   32'(g));
        chk("xfer_req_out1", 32'(req_out), 32'd1);
        chk("xfer_busy1",    32'(busy),    32'd1);
        chk("xfer_ack_pre",  32'(ack_out), 32'd0);
        ack_in = 1'b1;
        tick;
        chk("xfer_ack_hold", 32'(ack_out), 32'd1 << g);
        chk("xfer_req_hold", 32'(req_out), 32'd1);
        req[g] = 1'b0;
        tick;
        chk("xfer_req_rel",  32'(req_out), 32'd0);
        chk("xfer_ack_rel",  32'(ack_out), 32'd1 << g);
        chk("xfer_busy_rel", 32'(busy),    32'd1);
        ack_in = 1'b0;
        tick;
        chk("xfer_busy_end", 32'(busy),    32'd0);
        chk("xfer_ack_end",  32'(ack_out), 32'd0);
        chk("xfer_cnt",      32'(cnt),     32'(cnt_exp));
        if (restore) req[g] = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        req     = '0;
        ack_in  = 1'b0;
        err_clr = 1'b0;
        my_addr = 2'd2;
        ch_addr = '0;
        tick;
        tick;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick;

        // Fairness: all channels match and keep requesting.
        ch_addr = 8'hAA;
        req     = 4'hF;
        do_xfer(0, 1, 1'b1);
        do_xfer(1, 2, 1'b1);
        do_xfer(2, 3, 1'b1);
        do_xfer(3, 0, 1'b1);
        do_xfer(0, 1, 1'b0);
        req = '0;

        // Single transfer from ch1.
        ch_addr = 8'h08;
        req     = 4'b0010;
        do_xfer(1, 2, 1'b0);

        // Address filter: only ch3 matches.
        ch_addr = 8'hB1;
        req     = 4'hF;
        do_xfer(3, 3, 1'b1);
        do_xfer(3, 0, 1'b0);
        req = '0;

        // ACK_IN in IDLE is ignored.
        ack_in = 1'b1;
        tick;
        tick;
        chk("idle_ack_busy",    32'(busy),    32'd0);
        chk("idle_ack_req_out", 32'(req_out), 32'd0);
        ack_in = 1'b0;

        // Timeout, then a late ACK absorbed in REL.
        ch_addr = 8'hAA;
        req     = 4'b0001;
        tick;
        chk("to1_req_out", 32'(req_out), 32'd1);
        chk("to1_grant",   32'(grant),   32'd0);
        repeat (14) tick;
        chk("to1_req_out_14", 32'(req_out), 32'd1);
        chk("to1_timeout_14", 32'(timeout), 32'd0);
        chk("to1_err_14",     32'(err),     32'd0);
        tick;
        chk("to1_req_out_15", 32'(req_out), 32'd0);
        chk("to1_timeout_15", 32'(timeout), 32'd1);
        chk("to1_err_15",     32'(err),     32'd1);
        chk("to1_busy_15",    32'(busy),    32'd1);
        chk("to1_ack_15",     32'(ack_out), 32'd0);
        req    = '0;
        ack_in = 1'b1;
        tick;
        chk("late_timeout_pulse", 32'(timeout), 32'd0);
        chk("late_busy1",         32'(busy),    32'd1);
        chk("late_ack1",          32'(ack_out), 32'd0);
        tick;
        tick;
        chk("late_busy3", 32'(busy),    32'd1);
        chk("late_ack3",  32'(ack_out), 32'd0);
        ack_in = 1'b0;
        tick;
        chk("late_busy_end", 32'(busy), 32'd0);
        chk("late_cnt",      32'(cnt),  32'd0);
        chk("late_err",      32'(err),  32'd1);

        // Second timeout with ERR_CLR_IN in the same cycle: set wins.
        req = 4'b0001;
        tick;
        repeat (14) tick;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("to2_err",     32'(err),     32'd1);
        chk("to2_timeout", 32'(timeout), 32'd1);
        req = '0;
        tick;
        chk("to2_busy_end", 32'(busy), 32'd0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("err_clear", 32'(err), 32'd0);

        // ACK_IN on the last REQ cycle beats the timeout.
        req = 4'b0001;
        tick;
        repeat (14) tick;
        ack_in = 1'b1;
        tick;
        chk("lastack_ack",     32'(ack_out), 32'd1);
        chk("lastack_timeout", 32'(timeout), 32'd0);
        chk("lastack_req_out", 32'(req_out), 32'd1);
        chk("lastack_err",     32'(err),     32'd0);
        req = '0;
        tick;
        chk("lastack_req_rel", 32'(req_out), 32'd0);
        ack_in = 1'b0;
        tick;
        chk("lastack_busy", 32'(busy), 32'd0);
        chk("lastack_cnt",  32'(cnt),  32'd1);

        // Asynchronous reset in HOLD.
        req = 4'b0001;
        tick;
        ack_in = 1'b1;
        tick;
        chk("hold_ack", 32'(ack_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        req    = '0;
        ack_in = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;

        // Counter wrap with CNT_W=2.
        for (int k = 1; k <= 4; k++) begin
            req = 4'b0001;
            do_xfer(0, k % 4, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/req_ack_hub.md
Name: req_ack_hub

Overview:
Parametrised N-channel four-phase REQ/ACK hub. It generalises the point-to-point Req/Ack pairing between sibling blocks.
- Arbitrates between NUM_CH requesters whose channel address matches MY_ADDR_IN.
- Forwards the winner to a single downstream responder and returns that responder's acknowledge to the winning channel only.
- Adds round-robin fairness, a no-acknowledge timeout and a completed-transfer counter.

Parameters:
NUM_CH, 4, number of requester channels (>=2)
ADDR_W, 2, channel/local address width
TIMEOUT, 15, max cycles in REQ without ACK_IN before abort; 0 disables the timeout
CNT_W, 8, completed-transfer counter width
GID_W, $clog2(NUM_CH), grant index width (derived)

Ports:
CLK_IN  in  1  clock, all state on rising edge
RST_N_IN  in  1  asynchronous active-low reset
MY_ADDR_IN  in  ADDR_W  local address; only matching channels are eligible
REQ_IN  in  NUM_CH  per-channel four-phase request
CH_ADDR_IN  in  NUM_CH*ADDR_W  per-channel target address, channel i at [i*ADDR_W +: ADDR_W]
ACK_OUT  out  NUM_CH  per-channel acknowledge, one-hot or zero
REQ_OUT  out  1  downstream request
GRANT_OUT  out  GID_W  index of the channel owning REQ_OUT
ACK_IN  in  1  downstream acknowledge
BUSY_OUT  out  1  high in every state except IDLE
TIMEOUT_OUT  out  1  one-cycle pulse on abort
ERR_OUT  out  1  sticky timeout flag
ERR_CLR_IN  in  1  clears ERR_OUT
XFER_CNT_OUT  out  CNT_W  completed transfers, wraps at 2^CNT_W

Behaviour:
- All outputs are registered.
- Reset (asynchronous, RST_N_IN=0): state IDLE; ACK_OUT, REQ_OUT, GRANT_OUT, BUSY_OUT, TIMEOUT_OUT, ERR_OUT, XFER_CNT_OUT and timer all 0. Round-robin pointer = NUM_CH-1, so channel 0 has first priority.
- Reset asserted mid-transaction aborts immediately: no ACK_OUT, no count.
- Eligible(i) = REQ_IN[i] && CH_ADDR_IN[i] == MY_ADDR_IN.
  - Evaluated only in IDLE.
  - Address changes after grant are ignored.
- IDLE:
  - If any channel is eligible, pick the first eligible index searching upward from pointer+1, modulo NUM_CH.
  - Next edge: GRANT_OUT=idx, pointer=idx, REQ_OUT=1, BUSY_OUT=1, timer=0, state REQ.
  - Latency from REQ_IN rise to REQ_OUT rise is 1 cycle.
- REQ (REQ_OUT=1):
  - ACK_IN=1: next edge ACK_OUT[GRANT_OUT]=1, state HOLD.
  - Else, if TIMEOUT!=0 and timer==TIMEOUT-1: next edge REQ_OUT=0, TIMEOUT_OUT=1 for one cycle, ERR_OUT=1, state REL with abort flag set.
  - Else timer increments.
  - ACK_IN checked before timeout: ACK_IN arriving on the last cycle wins.
- HOLD (REQ_OUT=1, ACK_OUT[g]=1):
  - When REQ_IN[g]=0: next edge REQ_OUT=0, state REL.
  - A requester that withdraws before ACK_IN still completes normally; HOLD then lasts 1 cycle.
- REL (REQ_OUT=0):
  - When ACK_IN=0: next edge ACK_OUT[g]=0, BUSY_OUT=0, state IDLE.
  - XFER_CNT_OUT increments on that edge unless the abort flag is set.
  - On an aborted transfer ACK_OUT stays 0 throughout REL. REL absorbs a late ACK_IN; IDLE is never entered with ACK_IN=1 outstanding from this transfer.
- Minimum transaction: REQ 1 cycle, HOLD 1 cycle, REL 1 cycle, giving 4 edges IDLE to IDLE.
- No re-arbitration in the IDLE-exit cycle; a new grant is issued at the earliest on the edge after return to IDLE.
- ERR_OUT:
  - Set by abort, cleared by ERR_CLR_IN.
  - Set wins over clear when both occur in the same cycle.
- XFER_CNT_OUT wraps from 2^CNT_W-1 to 0 with no flag.
- ACK_OUT never has more than one bit set.
- ACK_IN high in IDLE is ignored.

Test Plan:
- Single transfer: MY_ADDR_IN=2, CH_ADDR ch1=2, REQ_IN=0b0010 held until ACK_OUT[1]; responder acks 1 cycle after REQ_OUT -> REQ_OUT rises 1 cycle after REQ_IN, GRANT_OUT=1, ACK_OUT=0b0010, ends with XFER_CNT_OUT=1, BUSY_OUT=0.
- Fairness: all 4 channels matched and requesting continuously, each dropping after ack -> grant order 0,1,2,3,0; no channel granted twice before the others.
- Address filter: REQ_IN=0b1111, only ch3 address == MY_ADDR_IN -> only GRANT_OUT=3 ever issued; ch0-2 never see ACK_OUT.
- Timeout: TIMEOUT=15, ACK_IN held 0 -> REQ_OUT drops on 15th REQ cycle, TIMEOUT_OUT one pulse, ERR_OUT=1, count unchanged; ERR_CLR_IN and a second timeout in the same cycle -> ERR_OUT stays 1.
- Late ACK after abort: ACK_IN rises 2 cycles after timeout, falls 3 later -> hub stays in REL (BUSY_OUT=1, ACK_OUT=0) until ACK_IN falls, then IDLE.
- Reset mid-HOLD plus counter wrap (CNT_W=2): RST_N_IN low during HOLD -> all outputs 0 asynchronously. After reset, 4 transfers -> XFER_CNT_OUT sequence 1,2,3,0.
